// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared types and helpers for the seven-segment scan display:
//   converter state encoding, segment patterns {A..G} (A = bit 6, 1 = lit),
//   a nibble-to-segment encoder and the minimum-digit calculation used to
//   reject under-sized DIGITS at elaboration.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG7_0    = 7'b1111110;
    localparam logic [6:0] SEG7_1    = 7'b0110000;
    localparam logic [6:0] SEG7_2    = 7'b1101101;
    localparam logic [6:0] SEG7_3    = 7'b1111001;
    localparam logic [6:0] SEG7_4    = 7'b0110011;
    localparam logic [6:0] SEG7_5    = 7'b1011011;
    localparam logic [6:0] SEG7_6    = 7'b1011111;
    localparam logic [6:0] SEG7_7    = 7'b1110000;
    localparam logic [6:0] SEG7_8    = 7'b1111111;
    localparam logic [6:0] SEG7_9    = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Logical (active-high) pattern; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7_encode = SEG7_0;
            4'd1:    seg7_encode = SEG7_1;
            4'd2:    seg7_encode = SEG7_2;
            4'd3:    seg7_encode = SEG7_3;
            4'd4:    seg7_encode = SEG7_4;
            4'd5:    seg7_encode = SEG7_5;
            4'd6:    seg7_encode = SEG7_6;
            4'd7:    seg7_encode = SEG7_7;
            4'd8:    seg7_encode = SEG7_8;
            4'd9:    seg7_encode = SEG7_9;
            default: seg7_encode = SEG_BLANK;
        endcase
    endfunction

    // Smallest d with 10^d > 2^width - 1 (valid for width < 64).
    function automatic int min_digits(input int width);
        longint unsigned maxv;
        longint unsigned p;
        int              d;
        maxv = (64'd1 << width) - 64'd1;
        p    = 64'd1;
        d    = 0;
        for (int k = 0; k < 20; k++) begin
            if (p <= maxv) begin
                p = p * 64'd10;
                d = d + 1;
            end
        end
        if (d == 0) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
//   Valid/ready input channel carrying the binary value to display.
//   master: producer (drives in_valid/in_data, sees in_ready)
//   slave : display block (sees in_valid/in_data, drives in_ready)
interface seg_scan_display_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dd_bin2bcd_seq.sv
// dd_bin2bcd_seq
//   Sequential double-dabble: one shift per clock, WIDTH shifts per value.
//   Ports:
//     clk, reset      clock, async active-high reset
//     in_valid_i/in_data_i/in_ready_o   input handshake
//     busy_o          conversion (or commit) in progress
//     bcd_o           DIGITS BCD nibbles, valid while commit_o is high
//     commit_o        one-cycle strobe: load bcd_o into the display
module dd_bin2bcd_seq
    import seg_scan_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    input  logic [WIDTH-1:0]    in_data_i,
    output logic                in_ready_o,
    output logic                busy_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                commit_o
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BCD_W-1:0] scratch_q;
    logic [BCD_W-1:0] scratch_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             commit_q;

    // Add-3 correction ahead of each shift so a nibble >= 5 carries correctly.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] > 4'd4)
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i && ready_q) begin
                        shreg_q   <= in_data_i;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {scratch_q, shreg_q} <= {scratch_adj, shreg_q} << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        commit_q <= 1'b1;
                        state_q  <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is forced low for as long as reset is held.
    assign in_ready_o = ready_q & ~reset;
    assign busy_o     = busy_q;
    assign bcd_o      = scratch_q;
    assign commit_o   = commit_q;

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Binary value in, multiplexed seven-segment digits out. The converter
//   result is committed atomically to a display register; a prescaler then
//   walks the digits most-significant first, blanking the first BLANK_CYC
//   cycles of every slot to avoid ghosting.
//   Ports:
//     clk, reset   clock, async active-high reset
//     in_if        valid/ready channel carrying the WIDTH-bit value
//     lzb_en       leading-zero blanking enable
//     busy         conversion in progress
//     seg          segments {A..G}, A = bit 6, polarity per SEG_ACTIVE_LOW
//     dig          digit enables, bit i = 10^i, polarity per DIG_ACTIVE_LOW
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 1024,
    parameter int BLANK_CYC      = 16,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_display_if.slave in_if,
    input  logic              lzb_en,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig
);
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("seg_scan_display: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("seg_scan_display: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("seg_scan_display: BLANK_CYC must be < SCAN_DIV");
    end

    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIG_INV = {DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_INV = {7{SEG_ACTIVE_LOW}};

    logic [4*DIGITS-1:0] bcd;
    logic                commit;

    dd_bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_if.in_valid),
        .in_data_i  (in_if.in_data),
        .in_ready_o (in_if.in_ready),
        .busy_o     (busy),
        .bcd_o      (bcd),
        .commit_o   (commit)
    );

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   lz_blank;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                cur_blank;

    // Prescaler and slot walk: slot counts down so the MSD comes first.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        slot_d  = slot_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            slot_d  = (slot_q == '0) ? SLOT_W'(DIGITS - 1) : slot_q - SLOT_W'(1);
        end
    end

    assign disp_d = commit ? bcd : disp_q;

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above & (disp_q[4*i +: 4] == 4'd0);
            lz_blank[i] = lzb_en & zero_above & (i > 0);
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        dig_d     = '0;
        seg_d     = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = lz_blank[i];
            end
        end
        if (presc_q >= PRE_W'(BLANK_CYC)) begin
            for (int i = 0; i < DIGITS; i++)
                dig_d[i] = (slot_q == SLOT_W'(i));
            seg_d = cur_blank ? SEG_BLANK : seg7_encode(cur_nib);
        end
    end

    // Polarity is folded in only here so all logic above stays active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            slot_q  <= SLOT_W'(DIGITS - 1);
            disp_q  <= '0;
            dig_q   <= DIG_INV;
            seg_q   <= SEG_INV;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            disp_q  <= disp_d;
            dig_q   <= dig_d ^ DIG_INV;
            seg_q   <= seg_d ^ SEG_INV;
        end
    end

    assign dig = dig_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    logic clk = 1'b0;
    logic reset;
    logic lzb;
    always #5 clk = ~clk;

    // A: defaults; B: fast scan; C: 16-bit, 5 digits, polarities inverted
    seg_scan_display_if #(.WIDTH(8))  ifa ();
    seg_scan_display_if #(.WIDTH(8))  ifb ();
    seg_scan_display_if #(.WIDTH(16)) ifc ();

    logic       busy_a, busy_b, busy_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [2:0] dig_a, dig_b;
    logic [4:0] dig_c;

    seg_scan_display dut_a (
        .clk(clk), .reset(reset), .in_if(ifa.slave), .lzb_en(lzb),
        .busy(busy_a), .seg(seg_a), .dig(dig_a));

    seg_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(8), .BLANK_CYC(2),
                       .DIG_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_if(ifb.slave), .lzb_en(lzb),
        .busy(busy_b), .seg(seg_b), .dig(dig_b));

    seg_scan_display #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(16), .BLANK_CYC(3),
                       .DIG_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .reset(reset), .in_if(ifc.slave), .lzb_en(lzb),
        .busy(busy_c), .seg(seg_c), .dig(dig_c));

    int errors = 0;
    int checks = 0;

    // Edges since reset release: after edge n, tick == n.
    longint tick;
    always @(posedge clk or posedge reset)
        if (reset) tick <= 0;
        else       tick <= tick + 1;

    // Displayed value per DUT: old_v before commit edge ct, new_v from it on.
    int     old_v [3];
    int     new_v [3];
    longint ct    [3];

    function automatic int p10(input int k);
        int r = 1;
        for (int j = 0; j < k; j++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;
            2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected pins after edge n, from elapsed time and the decimal value.
    function automatic void model(input int id, input longint n,
                                  output logic [7:0] ed, output logic [6:0] es);
        int nd, sd, bl, v, p, s;
        bit dl, sl;
        longint t;
        case (id)
            0:       begin nd = 3; sd = 1024; bl = 16; dl = 1; sl = 0; end
            1:       begin nd = 3; sd = 8;    bl = 2;  dl = 1; sl = 0; end
            default: begin nd = 5; sd = 16;   bl = 3;  dl = 0; sl = 1; end
        endcase
        t  = n - 1;
        v  = (ct[id] <= t) ? new_v[id] : old_v[id];
        p  = int'(t % sd);
        s  = nd - 1 - int'((t / sd) % nd);
        ed = '0;
        es = '0;
        if (p >= bl) begin
            ed[s] = 1'b1;
            if (!(lzb && s > 0 && v < p10(s))) es = pat((v / p10(s)) % 10);
        end
        if (dl) ed = ~ed & 8'((1 << nd) - 1);
        if (sl) es = ~es;
    endfunction

    function automatic logic [7:0] odig(input int id);
        case (id)
            0:       return {5'b0, dig_a};
            1:       return {5'b0, dig_b};
            default: return {3'b0, dig_c};
        endcase
    endfunction

    function automatic logic [6:0] oseg(input int id);
        case (id)
            0:       return seg_a;
            1:       return seg_b;
            default: return seg_c;
        endcase
    endfunction

    function automatic logic ordy(input int id);
        case (id)
            0:       return ifa.in_ready;
            1:       return ifb.in_ready;
            default: return ifc.in_ready;
        endcase
    endfunction

    task automatic drive(input int id, input logic v, input int d);
        case (id)
            0:       begin ifa.in_valid = v; ifa.in_data = 8'(d);  end
            1:       begin ifb.in_valid = v; ifb.in_data = 8'(d);  end
            default: begin ifc.in_valid = v; ifc.in_data = 16'(d); end
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            old_v[i] = 0; new_v[i] = 0; ct[i] = 0;
        end
    endtask

    // Offer one value; e = acceptance edge (-1 on timeout), low = ready-low cycles.
    task automatic offer(input int id, input int val, output longint e, output int low);
        e   = -1;
        low = 0;
        @(negedge clk);
        drive(id, 1'b1, val);
        for (int k = 0; k < 100 && e < 0; k++) begin
            if (ordy(id)) e = tick + 1;
            @(negedge clk);
        end
        drive(id, 1'b0, 0);
        if (e >= 0) begin
            old_v[id] = new_v[id];
            new_v[id] = val;
            ct[id]    = e + ((id == 2) ? 16 : 8) + 1;
            while (ordy(id) == 1'b0 && low < 100) begin
                low++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lzb   = 1'b0;
        drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
        clear_model();
        repeat (2) @(negedge clk);
        checks++;
        if (dig_a !== 3'b111 || seg_a !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_pins_a dig=%b seg=%b want 111/0000000", dig_a, seg_a);
        end
        checks++;
        if (dig_c !== 5'b00000 || seg_c !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_pins_c dig=%b seg=%b want 00000/1111111", dig_c, seg_c);
        end
        checks++;
        if (ifa.in_ready !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready rdy=%b busy=%b want 0/0", ifa.in_ready, busy_a);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready rdy=%b want 1", ifa.in_ready);
        end
    endtask

    task automatic test_basic_255();
        longint e;
        int     low;
        logic [7:0] ed;
        logic [6:0] es;
        lzb = 1'b0;
        offer(0, 255, e, low);
        checks++;
        if (e < 0 || low != 9) begin
            errors++;
            $display("FAIL latency_255 accept=%0d ready_low=%0d want 9", e, low);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_255 busy=%b want 0", busy_a);
        end
        repeat (3100) begin
            @(negedge clk);
            model(0, tick, ed, es);
            checks++;
            if (odig(0) !== ed || oseg(0) !== es) begin
                errors++;
                $display("FAIL scan_255 n=%0d dig=%b seg=%b want %b/%b", tick, odig(0), oseg(0), ed, es);
            end
        end
    endtask

    task automatic test_lzb();
        longint e;
        int     low;
        int     vals [3] = '{7, 0, 105};
        logic [7:0] ed;
        logic [6:0] es;
        lzb = 1'b1;
        foreach (vals[i]) begin
            offer(0, vals[i], e, low);
            checks++;
            if (e < 0 || low != 9) begin
                errors++;
                $display("FAIL lzb_accept val=%0d accept=%0d ready_low=%0d", vals[i], e, low);
            end
            repeat (3100) begin
                @(negedge clk);
                model(0, tick, ed, es);
                checks++;
                if (odig(0) !== ed || oseg(0) !== es) begin
                    errors++;
                    $display("FAIL lzb_scan val=%0d n=%0d dig=%b seg=%b want %b/%b",
                             vals[i], tick, odig(0), oseg(0), ed, es);
                end
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_back_to_back();
        longint e1 = -1;
        longint e2 = -1;
        logic [7:0] ed;
        logic [6:0] es;
        @(negedge clk);
        drive(1, 1'b1, 12);
        for (int k = 0; k < 200 && e2 < 0; k++) begin
            if (ordy(1)) begin
                if (e1 < 0) begin
                    e1 = tick + 1; old_v[1] = new_v[1]; new_v[1] = 12; ct[1] = e1 + 9;
                end else begin
                    e2 = tick + 1; old_v[1] = 12; new_v[1] = 34; ct[1] = e2 + 9;
                end
            end
            @(negedge clk);
            if (e1 >= 0 && tick == e1) drive(1, 1'b1, 34);
            model(1, tick, ed, es);
            checks++;
            if (odig(1) !== ed || oseg(1) !== es) begin
                errors++;
                $display("FAIL b2b_scan n=%0d dig=%b seg=%b want %b/%b", tick, odig(1), oseg(1), ed, es);
            end
        end
        drive(1, 1'b0, 0);
        checks++;
        if (e1 < 0 || e2 - e1 != 10) begin
            errors++;
            $display("FAIL b2b_spacing first=%0d second=%0d want gap 10", e1, e2);
        end
        repeat (60) begin
            @(negedge clk);
            model(1, tick, ed, es);
            checks++;
            if (odig(1) !== ed || oseg(1) !== es) begin
                errors++;
                $display("FAIL b2b_tail n=%0d dig=%b seg=%b want %b/%b", tick, odig(1), oseg(1), ed, es);
            end
        end
    endtask

    task automatic test_scan_timing();
        int active = 0;
        logic [2:0] prev = 3'b111;
        logic [2:0] want;
        logic [7:0] ed;
        logic [6:0] es;
        repeat (72) begin
            @(negedge clk);
            model(1, tick, ed, es);
            checks++;
            if (odig(1) !== ed || oseg(1) !== es) begin
                errors++;
                $display("FAIL slot_scan n=%0d dig=%b seg=%b want %b/%b", tick, odig(1), oseg(1), ed, es);
            end
            if (dig_b != 3'b111) begin
                active++;
                if (prev != 3'b111 && dig_b != prev) begin
                    want = (prev == 3'b011) ? 3'b101 : (prev == 3'b101) ? 3'b110 : 3'b011;
                    checks++;
                    if (dig_b !== want) begin
                        errors++;
                        $display("FAIL slot_order after=%b got=%b want %b", prev, dig_b, want);
                    end
                end
                prev = dig_b;
            end
        end
        checks++;
        if (active != 54) begin
            errors++;
            $display("FAIL active_cycles got=%0d want 54", active);
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [7:0] ed;
        logic [6:0] es;
        bit acc = 0;
        lzb = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 200);
        for (int k = 0; k < 50 && !acc; k++) begin
            if (ordy(0)) acc = 1;
            @(negedge clk);
        end
        drive(0, 1'b0, 0);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL midreset_accept timeout");
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (dig_a !== 3'b111 || seg_a !== 7'b0000000 || ifa.in_ready !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pins dig=%b seg=%b rdy=%b busy=%b want 111/0000000/0/0",
                     dig_a, seg_a, ifa.in_ready, busy_a);
        end
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready rdy=%b want 1", ifa.in_ready);
        end
        repeat (3100) begin
            @(negedge clk);
            model(0, tick, ed, es);
            checks++;
            if (odig(0) !== ed || oseg(0) !== es) begin
                errors++;
                $display("FAIL midreset_scan n=%0d dig=%b seg=%b want %b/%b", tick, odig(0), oseg(0), ed, es);
            end
        end
    endtask

    task automatic test_wide_inverted();
        longint e;
        int     low;
        logic [7:0] ed;
        logic [6:0] es;
        offer(2, 65535, e, low);
        checks++;
        if (e < 0 || low != 17) begin
            errors++;
            $display("FAIL latency_65535 accept=%0d ready_low=%0d want 17", e, low);
        end
        repeat (100) begin
            @(negedge clk);
            model(2, tick, ed, es);
            checks++;
            if (odig(2) !== ed || oseg(2) !== es) begin
                errors++;
                $display("FAIL wide_scan n=%0d dig=%b seg=%b want %b/%b", tick, odig(2), oseg(2), ed, es);
            end
        end
    endtask

    task automatic test_random();
        longint e;
        int     low;
        int     v;
        logic [7:0] ed;
        logic [6:0] es;
        for (int it = 0; it < 6; it++) begin
            lzb = 1'($urandom_range(0, 1));
            v = int'($urandom_range(0, 255));
            offer(1, v, e, low);
            checks++;
            if (e < 0 || low != 9) begin
                errors++;
                $display("FAIL rand_b_accept val=%0d ready_low=%0d", v, low);
            end
            repeat (30) begin
                @(negedge clk);
                model(1, tick, ed, es);
                checks++;
                if (odig(1) !== ed || oseg(1) !== es) begin
                    errors++;
                    $display("FAIL rand_b_scan val=%0d dig=%b seg=%b want %b/%b", v, odig(1), oseg(1), ed, es);
                end
            end
            v = int'($urandom_range(0, 65535));
            offer(2, v, e, low);
            checks++;
            if (e < 0 || low != 17) begin
                errors++;
                $display("FAIL rand_c_accept val=%0d ready_low=%0d", v, low);
            end
            repeat (90) begin
                @(negedge clk);
                model(2, tick, ed, es);
                checks++;
                if (odig(2) !== ed || oseg(2) !== es) begin
                    errors++;
                    $display("FAIL rand_c_scan val=%0d dig=%b seg=%b want %b/%b", v, odig(2), oseg(2), ed, es);
                end
            end
        end
        lzb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_255();
        test_lzb();
        test_back_to_back();
        test_scan_timing();
        test_reset_mid_conv();
        test_wide_inverted();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
